ex_mem_pipe_stage: RTL

Parametrised EX/MEM pipeline stage with a valid/ready handshake, a two-entry skid buffer, and synchronous flush. It sits between the execute stage (ALU result, zero flag, store data, opcode) and the memory stage. Unlike a plain clocked register, it can stall the execute stage without a combinational ready path, and it can squash in-flight instructions on a branch or jump redirect. Invalidated slots carry a NOP opcode downstream.

---
 rtl/ex_mem_pipe_if.sv | 33 +++
 rtl/ex_mem_pipe_stage.sv | 101 ++++++++++
 2 files changed

// File: rtl/ex_mem_pipe_if.sv
// EX-to-MEM stream bundle: the EX-side request/payload and the MEM-side
// result/payload, each with its own valid/ready pair.
interface ex_mem_pipe_if #(
    parameter int DATA_W  = 20,
    parameter int STORE_W = 16,
    parameter int OP_W    = 4
);
    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high. A valid source holds its payload stable until that transfer.
    logic               in_valid;
    logic               in_ready;
    logic [OP_W-1:0]    opcode;
    logic               alu_zero;
    logic [DATA_W-1:0]  alu_result;
    logic [STORE_W-1:0] store_data;

    logic               out_valid;
    logic               out_ready;
    logic [OP_W-1:0]    out_opcode;
    logic               out_alu_zero;
    logic [DATA_W-1:0]  out_alu_result;
    logic [DATA_W-1:0]  out_store_data;

    modport master (
        output in_valid, opcode, alu_zero, alu_result, store_data, out_ready,
        input  in_ready, out_valid, out_opcode, out_alu_zero, out_alu_result, out_store_data
    );

    modport slave (
        input  in_valid, opcode, alu_zero, alu_result, store_data, out_ready,
        output in_ready, out_valid, out_opcode, out_alu_zero, out_alu_result, out_store_data
    );
endinterface

// File: rtl/ex_mem_pipe_stage.sv
// EX/MEM pipeline register with a two-entry skid buffer and synchronous flush.
// Empty or squashed slots present NOP_OPCODE with all other fields zero.
module ex_mem_pipe_stage #(
    parameter int DATA_W     = 20,
    parameter int STORE_W    = 16,
    parameter int OP_W       = 4,
    parameter int NOP_OPCODE = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    ex_mem_pipe_if.slave       bus,
    output logic [1:0]         occupancy
);
    // State bits double as the slot valid bits: {skid.valid, main.valid}.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]   opcode;
        logic              zero;
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] store;
    } entry_t;

    state_t state_q;
    entry_t main_q;
    entry_t skid_q;
    entry_t in_entry;
    entry_t bubble;
    logic   accept;
    logic   drain;

    always_comb begin
        bubble        = '0;
        bubble.opcode = OP_W'(NOP_OPCODE);
    end

    always_comb begin
        in_entry.opcode = bus.opcode;
        in_entry.zero   = bus.alu_zero;
        in_entry.result = bus.alu_result;
        in_entry.store  = DATA_W'(bus.store_data);
    end

    // in_ready depends on registered state only, never on out_ready or flush.
    assign bus.in_ready = ~state_q[1];
    assign bus.out_valid = state_q[0];
    assign accept = bus.in_valid & bus.in_ready;
    assign drain  = bus.out_valid & bus.out_ready;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            state_q <= EMPTY;
            main_q  <= bubble;
            skid_q  <= bubble;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_q  <= in_entry;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        main_q <= in_entry;
                    end else if (accept) begin
                        skid_q  <= in_entry;
                        state_q <= FULL;
                    end else if (drain) begin
                        main_q  <= bubble;
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        main_q  <= skid_q;
                        skid_q  <= bubble;
                        state_q <= ONE;
                    end
                end
                default: begin
                    // Skid-only is unreachable; recover to a clean empty stage.
                    state_q <= EMPTY;
                    main_q  <= bubble;
                    skid_q  <= bubble;
                end
            endcase
        end
    end

    assign bus.out_opcode     = main_q.opcode;
    assign bus.out_alu_zero   = main_q.zero;
    assign bus.out_alu_result = main_q.result;
    assign bus.out_store_data = main_q.store;
    assign occupancy = {1'b0, state_q[0]} + {1'b0, state_q[1]};
endmodule
